// File: rtl/dispatch_ctrl_if.sv
// Dispatch control bus: fetch-buffer valids, resource counts and squash in;
// grant count, per-slot grants, stall and FSM state out.
// master: drives the request side (fetch buffer / resource trackers).
// slave : the dispatch controller.
// Uses codebase macro `N_WAY (superscalar width); W = $clog2(`N_WAY)+1.

`ifndef N_WAY
`define N_WAY 3
`endif

interface dispatch_ctrl_if;
  localparam int unsigned N_WAY = `N_WAY;
  localparam int unsigned W     = $clog2(N_WAY) + 1;

  logic [N_WAY-1:0] inst_valid;
  logic [W-1:0]     free_num;
  logic [W-1:0]     rob_free_num;
  logic [W-1:0]     rs_free_num;
  logic             squash;
  logic [W-1:0]     dispatch_num;
  logic [N_WAY-1:0] dispatched;
  logic             stall;
  logic [1:0]       state;

  modport master (
    output inst_valid, free_num, rob_free_num, rs_free_num, squash,
    input  dispatch_num, dispatched, stall, state
  );

  modport slave (
    input  inst_valid, free_num, rob_free_num, rs_free_num, squash,
    output dispatch_num, dispatched, stall, state
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: grants the longest in-order run of valid slots that
// every downstream resource (free list, ROB, RS) can accept this cycle, and
// sequences RUN / STALL / FLUSH around squashes.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   bus          dispatch_ctrl_if.slave (inst_valid, free_num, rob_free_num,
//                rs_free_num, squash in; dispatch_num, dispatched, stall,
//                state out)
//   stall_cycles 32-bit stall-cycle counter, only with DISPATCH_PERF_EN
// Grant outputs are combinational (zero latency); state is registered.
// Optional feature macro: DISPATCH_PERF_EN.

`ifndef N_WAY
`define N_WAY 3
`endif

module dispatch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  dispatch_ctrl_if.slave   bus
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int unsigned N_WAY = `N_WAY;
  localparam int unsigned W     = $clog2(N_WAY) + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [W-1:0]     lead_c;
  logic             run_c;
  logic [W-1:0]     grant_c;
  logic [W-1:0]     dispatch_num_c;
  logic [N_WAY-1:0] dispatched_c;
  logic             stall_c;

  function automatic logic [W-1:0] min2(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Count of contiguous valid slots from slot 0; the first hole ends the run.
  always_comb begin
    lead_c = '0;
    run_c  = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      run_c = run_c & bus.inst_valid[i];
      if (run_c) lead_c = lead_c + W'(1);
    end
  end

  // Full-width minimum over the in-order run and all three resource counts.
  assign grant_c = min2(min2(lead_c, bus.free_num),
                        min2(bus.rob_free_num, bus.rs_free_num));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and grant outputs.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    dispatch_num_c = grant_c;
    dispatched_c   = '0;

    if (reset || bus.squash || (state_q == ST_FLUSH)) dispatch_num_c = '0;

    for (int i = 0; i < N_WAY; i++) begin
      dispatched_c[i] = (W'(i) < dispatch_num_c);
    end

    if (bus.squash) begin
      // Squash from any state (re)starts the recovery window.
      state_d     = ST_FLUSH;
      flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if ((lead_c != '0) && (grant_c == '0)) state_d = ST_STALL;
        end
        ST_STALL: begin
          if (grant_c != '0) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          if (flush_cnt_q == '0) state_d = ST_RUN;
          else                   flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
        default: begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end
      endcase
    end
  end

  // Squash cycles with work pending still count as stalled; FLUSH does not.
  assign stall_c = (lead_c != '0) && (dispatch_num_c == '0) &&
                   (state_q != ST_FLUSH) && !reset;

  assign bus.dispatch_num = dispatch_num_c;
  assign bus.dispatched   = dispatched_c;
  assign bus.stall        = stall_c;
  assign bus.state        = state_q;

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Free-running stall counter, wraps at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed table of vectors followed by random
// stimulus checked against a cycle-level behavioural model.

`ifndef N_WAY
`define N_WAY 3
`endif

module tb_dispatch_ctrl;
  localparam int unsigned N  = `N_WAY;
  localparam int unsigned W  = $clog2(N) + 1;
  localparam int unsigned FC = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dispatch_ctrl_if bus ();

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  dispatch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef DISPATCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    bit rst; bit sq; int v; int f; int r; int s;
    int en; int ed; int es; int est;
  } vec_t;

  vec_t tbl [32];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: cycles of FLUSH still owed, and whether dispatch is stalled.
  int          flush_left = 0;
  bit          stalled    = 1'b0;
  logic [31:0] perf_m     = '0;

  function automatic vec_t mk(input bit rst, input bit sq, input int v,
                              input int f, input int r, input int s,
                              input int en, input int ed, input int es,
                              input int est);
    vec_t t;
    t.rst = rst; t.sq = sq; t.v = v; t.f = f; t.r = r; t.s = s;
    t.en = en; t.ed = ed; t.es = es; t.est = est;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at vector %0d: got %0d expected %0d", name, n_vec, act, exp_v);
    end
  endtask

  // One cycle: drive, compare (table or model), then advance the model.
  task automatic cyc(input bit rst, input bit sq, input int v, input int f,
                     input int r, input int s, input bit use_tbl,
                     input int en, input int ed, input int es, input int est);
    int lead, g, xn, xd, xs, xst;
    @(negedge clock);
    reset            = rst;
    bus.squash       = sq;
    bus.inst_valid   = N'(v);
    bus.free_num     = W'(f);
    bus.rob_free_num = W'(r);
    bus.rs_free_num  = W'(s);
    #1;
    lead = 0;
    for (int i = 0; i < N; i++) begin
      if (((v >> i) & 1) == 0) break;
      lead++;
    end
    g = lead;
    if (f < g) g = f;
    if (r < g) g = r;
    if (s < g) g = s;
    xst = (flush_left > 0) ? 2 : (stalled ? 1 : 0);
    xn  = (rst || sq || flush_left > 0) ? 0 : g;
    xd  = (1 << xn) - 1;
    xs  = (lead > 0 && xn == 0 && flush_left == 0 && !rst) ? 1 : 0;
    if (use_tbl) begin
      xn = en; xd = ed; xs = es; xst = est;
    end
    n_vec++;
    chk("dispatch_num", int'(bus.dispatch_num), xn);
    chk("dispatched",   int'(bus.dispatched),   xd);
    chk("stall",        int'(bus.stall),        xs);
    chk("state",        int'(bus.state),        xst);
`ifdef DISPATCH_PERF_EN
    chk("stall_cycles", int'(stall_cycles), int'(perf_m));
`endif
    if (rst) begin
      flush_left = 0; stalled = 1'b0; perf_m = '0;
    end else begin
      if (xs != 0) perf_m = perf_m + 32'd1;
      if (sq) begin
        flush_left = FC; stalled = 1'b0;
      end else if (flush_left > 0) begin
        flush_left--; stalled = 1'b0;
      end else if (stalled) begin
        stalled = (g == 0);
      end else begin
        stalled = (lead > 0 && g == 0);
      end
    end
  endtask

  initial begin
    //          rst sq  v     f  r  s   num disp   stall state
    tbl[0]  = mk(1, 0, 3'b111, 3, 3, 3, 0, 3'b000, 0, 0);
    tbl[1]  = mk(0, 0, 3'b111, 3, 2, 3, 2, 3'b011, 0, 0);
    tbl[2]  = mk(0, 0, 3'b101, 3, 3, 3, 1, 3'b001, 0, 0);
    tbl[3]  = mk(0, 0, 3'b110, 3, 3, 3, 0, 3'b000, 0, 0);
    tbl[4]  = mk(0, 0, 3'b111, 1, 3, 2, 1, 3'b001, 0, 0);
    tbl[5]  = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 0);
    tbl[6]  = mk(0, 0, 3'b111, 0, 3, 3, 0, 3'b000, 1, 0);
    tbl[7]  = mk(0, 0, 3'b111, 0, 3, 3, 0, 3'b000, 1, 1);
    tbl[8]  = mk(0, 0, 3'b111, 0, 3, 3, 0, 3'b000, 1, 1);
    tbl[9]  = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 1);
    tbl[10] = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 0);
    tbl[11] = mk(0, 1, 3'b111, 3, 3, 3, 0, 3'b000, 1, 0);
    tbl[12] = mk(0, 0, 3'b111, 3, 3, 3, 0, 3'b000, 0, 2);
    tbl[13] = mk(0, 0, 3'b111, 3, 3, 3, 0, 3'b000, 0, 2);
    tbl[14] = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 0);
    tbl[15] = mk(0, 1, 3'b111, 3, 3, 3, 0, 3'b000, 1, 0);
    tbl[16] = mk(0, 0, 3'b111, 3, 3, 3, 0, 3'b000, 0, 2);
    tbl[17] = mk(0, 1, 3'b111, 3, 3, 3, 0, 3'b000, 0, 2);
    tbl[18] = mk(0, 0, 3'b111, 3, 3, 3, 0, 3'b000, 0, 2);
    tbl[19] = mk(0, 0, 3'b111, 3, 3, 3, 0, 3'b000, 0, 2);
    tbl[20] = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 0);
    tbl[21] = mk(0, 0, 3'b111, 0, 3, 3, 0, 3'b000, 1, 0);
    tbl[22] = mk(0, 0, 3'b111, 0, 3, 3, 0, 3'b000, 1, 1);
    tbl[23] = mk(1, 1, 3'b111, 0, 3, 3, 0, 3'b000, 0, 1);
    tbl[24] = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 0);
    tbl[25] = mk(0, 0, 3'b111, 2, 3, 1, 1, 3'b001, 0, 0);
    tbl[26] = mk(0, 0, 3'b011, 3, 3, 3, 2, 3'b011, 0, 0);
    tbl[27] = mk(0, 0, 3'b000, 3, 3, 3, 0, 3'b000, 0, 0);
    tbl[28] = mk(0, 0, 3'b111, 0, 0, 0, 0, 3'b000, 1, 0);
    tbl[29] = mk(0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 1);
    tbl[30] = mk(0, 0, 3'b001, 1, 1, 1, 1, 3'b001, 0, 1);
    tbl[31] = mk(0, 0, 3'b111, 3, 3, 3, 3, 3'b111, 0, 0);

    reset            = 1'b1;
    bus.squash       = 1'b0;
    bus.inst_valid   = '0;
    bus.free_num     = '0;
    bus.rob_free_num = '0;
    bus.rs_free_num  = '0;
    repeat (2) @(posedge clock);

    // Directed vectors assume a 3-wide machine.
    if (N == 3) begin
      for (int k = 0; k < 32; k++) begin
        cyc(tbl[k].rst, tbl[k].sq, tbl[k].v, tbl[k].f, tbl[k].r, tbl[k].s,
            1'b1, tbl[k].en, tbl[k].ed, tbl[k].es, tbl[k].est);
      end
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      bit rr, sq;
      rr = ($urandom_range(0, 39) == 0);
      sq = ($urandom_range(0, 9) == 0);
      cyc(rr, sq, int'($urandom_range(0, (1 << N) - 1)),
          int'($urandom_range(0, N)), int'($urandom_range(0, N)),
          int'($urandom_range(0, N)), 1'b0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
